sequenceur_partie: RTL and testbench

- Game-level controller for the three-brick game.
- Sequences a game (wait, serve, play, win/lose) and moves the paddle from boutonPlus/boutonMoins once per video frame.
- Tracks live bricks, score and lives, and issues one ball-step pulse per frame to the ball datapath.
- Sits between the VGA timing/pixel datapath (frame pulse and collision flags in) and the 7-segment driver (score/lives out).

---
 rtl/sequenceur_partie.sv | 176 +++++++++++++++++
 tb/tb_sequenceur_partie.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sequenceur_partie.sv
// Game-level controller for the three-brick game: sequences wait/serve/play/win/lose,
// moves the paddle once per frame and keeps bricks, score and lives.
module sequenceur_partie #(
    parameter int LARGEUR_ECRAN    = 640,
    parameter int LARGEUR_RAQUETTE = 64,
    parameter int PAS_RAQUETTE     = 4,
    parameter int VIES_INIT        = 3,
    parameter int DELAI_SERVICE    = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       boutonPlus,
    input  logic       boutonMoins,
    input  logic       debut_trame,
    input  logic [2:0] collision_brique,
    input  logic       balle_perdue,
    output logic [9:0] raquette_x,
    output logic [2:0] briques_actives,
    output logic [3:0] score,
    output logic [1:0] vies,
    output logic [2:0] etat,
    output logic       maj_balle,
    output logic       servir
);

    localparam int          CW        = $clog2(DELAI_SERVICE + 1);
    localparam logic [10:0] X_MAX     = 11'(LARGEUR_ECRAN - LARGEUR_RAQUETTE);
    localparam logic [9:0]  X_MAX10   = 10'(LARGEUR_ECRAN - LARGEUR_RAQUETTE);
    localparam logic [9:0]  X_CENTRE  = 10'((LARGEUR_ECRAN - LARGEUR_RAQUETTE) / 2);
    localparam logic [10:0] PAS11     = 11'(PAS_RAQUETTE);
    localparam logic [9:0]  PAS10     = 10'(PAS_RAQUETTE);
    localparam logic [1:0]  VIES_DEP  = 2'(VIES_INIT);
    localparam logic [CW-1:0] DELAI_M1 = CW'(DELAI_SERVICE - 1);

    typedef enum logic [2:0] {
        ATTENTE = 3'd0,
        SERVICE = 3'd1,
        JEU     = 3'd2,
        GAGNE   = 3'd3,
        PERDU   = 3'd4
    } etat_t;

    etat_t etat_q, etat_d;

    logic [1:0]    sync_plus, sync_moins;
    logic          prev_plus;
    logic [CW-1:0] compteur, compteur_d;

    logic [9:0]  x_d;
    logic [2:0]  briques_d;
    logic [3:0]  score_d;
    logic [1:0]  vies_d;
    logic        maj_d, servir_d;

    logic        plus_lvl, moins_lvl, plus_front;
    logic [10:0] x_somme;
    logic [9:0]  x_deplace;
    logic [2:0]  touches, briques_rest;
    logic [3:0]  nb_touches;

    assign plus_lvl   = sync_plus[1];
    assign moins_lvl  = sync_moins[1];
    assign plus_front = sync_plus[1] & ~prev_plus;

    // Paddle candidate position; the 11-bit sum keeps the right-edge clamp free of wrap-around.
    always_comb begin
        x_somme   = {1'b0, raquette_x} + PAS11;
        x_deplace = raquette_x;
        if (plus_lvl && !moins_lvl) begin
            x_deplace = (x_somme > X_MAX) ? X_MAX10 : x_somme[9:0];
        end else if (moins_lvl && !plus_lvl) begin
            x_deplace = (raquette_x < PAS10) ? 10'd0 : raquette_x - PAS10;
        end
    end

    assign touches      = collision_brique & briques_actives;
    assign briques_rest = briques_actives & ~touches;
    assign nb_touches   = {3'b000, touches[0]} + {3'b000, touches[1]} + {3'b000, touches[2]};

    always_comb begin
        etat_d     = etat_q;
        x_d        = raquette_x;
        briques_d  = briques_actives;
        score_d    = score;
        vies_d     = vies;
        compteur_d = compteur;
        maj_d      = 1'b0;
        servir_d   = 1'b0;
        case (etat_q)
            ATTENTE: begin
                if (plus_front) begin
                    etat_d     = SERVICE;
                    compteur_d = '0;
                end
            end
            SERVICE: begin
                if (debut_trame) begin
                    x_d = x_deplace;
                    if (compteur == DELAI_M1) begin
                        servir_d   = 1'b1;
                        etat_d     = JEU;
                        compteur_d = '0;
                    end else begin
                        compteur_d = compteur + 1'b1;
                    end
                end
            end
            JEU: begin
                if (debut_trame) begin
                    x_d   = x_deplace;
                    maj_d = 1'b1;
                end
                briques_d = briques_rest;
                score_d   = score + nb_touches;
                // Clearing the last brick wins even if the ball is lost in the same cycle.
                if (briques_rest == 3'b000) begin
                    etat_d = GAGNE;
                end else if (balle_perdue) begin
                    vies_d = vies - 2'd1;
                    if (vies == 2'd1) begin
                        etat_d = PERDU;
                    end else begin
                        etat_d     = SERVICE;
                        compteur_d = '0;
                    end
                end
            end
            GAGNE, PERDU: begin
                if (plus_front && moins_lvl) begin
                    etat_d    = ATTENTE;
                    x_d       = X_CENTRE;
                    briques_d = 3'b111;
                    score_d   = 4'd0;
                    vies_d    = VIES_DEP;
                end
            end
            default: etat_d = ATTENTE;
        endcase
    end

    // With enable low every register holds; only the two strobes are pulled low.
    always_ff @(posedge clk) begin
        if (reset) begin
            etat_q          <= ATTENTE;
            raquette_x      <= X_CENTRE;
            briques_actives <= 3'b111;
            score           <= 4'd0;
            vies            <= VIES_DEP;
            compteur        <= '0;
            maj_balle       <= 1'b0;
            servir          <= 1'b0;
            sync_plus       <= 2'b00;
            sync_moins      <= 2'b00;
            prev_plus       <= 1'b0;
        end else if (enable) begin
            etat_q          <= etat_d;
            raquette_x      <= x_d;
            briques_actives <= briques_d;
            score           <= score_d;
            vies            <= vies_d;
            compteur        <= compteur_d;
            maj_balle       <= maj_d;
            servir          <= servir_d;
            sync_plus       <= {sync_plus[0], boutonPlus};
            sync_moins      <= {sync_moins[0], boutonMoins};
            prev_plus       <= sync_plus[1];
        end else begin
            maj_balle <= 1'b0;
            servir    <= 1'b0;
        end
    end

    assign etat = etat_q;

endmodule

// File: tb/tb_sequenceur_partie.sv
// Directed bench for sequenceur_partie: hand-written start/serve sequences followed by
// a table of {inputs, cycle count, expected outputs} rows covering three full games.
module tb_sequenceur_partie;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       boutonPlus;
    logic       boutonMoins;
    logic       debut_trame;
    logic [2:0] collision_brique;
    logic       balle_perdue;
    logic [9:0] raquette_x;
    logic [2:0] briques_actives;
    logic [3:0] score;
    logic [1:0] vies;
    logic [2:0] etat;
    logic       maj_balle;
    logic       servir;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic       en;
        logic       plus;
        logic       moins;
        logic       dt;
        logic [2:0] col;
        logic       bp;
        int         cycles;
        logic [2:0] e_etat;
        logic [9:0] e_x;
        logic [2:0] e_briq;
        logic [3:0] e_score;
        logic [1:0] e_vies;
        logic       e_maj;
    } vec_t;

    vec_t vecs[$];

    sequenceur_partie dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .boutonPlus(boutonPlus),
        .boutonMoins(boutonMoins),
        .debut_trame(debut_trame),
        .collision_brique(collision_brique),
        .balle_perdue(balle_perdue),
        .raquette_x(raquette_x),
        .briques_actives(briques_actives),
        .score(score),
        .vies(vies),
        .etat(etat),
        .maj_balle(maj_balle),
        .servir(servir)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        enable           = v.en;
        boutonPlus       = v.plus;
        boutonMoins      = v.moins;
        debut_trame      = v.dt;
        collision_brique = v.col;
        balle_perdue     = v.bp;
        repeat (v.cycles) tick();
    endtask

    function automatic vec_t mk(input logic en, input logic plus, input logic moins,
                                input logic dt, input logic [2:0] col, input logic bp,
                                input int cycles, input logic [2:0] e_etat,
                                input logic [9:0] e_x, input logic [2:0] e_briq,
                                input logic [3:0] e_score, input logic [1:0] e_vies,
                                input logic e_maj);
        vec_t v;
        v.en = en; v.plus = plus; v.moins = moins; v.dt = dt; v.col = col; v.bp = bp;
        v.cycles = cycles; v.e_etat = e_etat; v.e_x = e_x; v.e_briq = e_briq;
        v.e_score = e_score; v.e_vies = e_vies; v.e_maj = e_maj;
        return v;
    endfunction

    task automatic checkAll(input string tag, input int e_etat, input int e_x,
                            input int e_briq, input int e_score, input int e_vies);
        checkOutput({tag, "_etat"}, int'(etat), e_etat);
        checkOutput({tag, "_x"}, int'(raquette_x), e_x);
        checkOutput({tag, "_briques"}, int'(briques_actives), e_briq);
        checkOutput({tag, "_score"}, int'(score), e_score);
        checkOutput({tag, "_vies"}, int'(vies), e_vies);
    endtask

    initial begin
        int servir_count;

        reset = 1'b1; enable = 1'b1; boutonPlus = 1'b0; boutonMoins = 1'b0;
        debut_trame = 1'b0; collision_brique = 3'b000; balle_perdue = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        checkAll("reset", 0, 288, 7, 0, 3);
        checkOutput("reset_maj", int'(maj_balle), 0);
        checkOutput("reset_servir", int'(servir), 0);

        // Start press: visible in etat on the third edge after the raw rise.
        boutonPlus = 1'b1;
        tick(); tick();
        checkOutput("press_2cyc_etat", int'(etat), 0);
        tick();
        checkOutput("press_3cyc_etat", int'(etat), 1);
        boutonPlus = 1'b0;
        repeat (3) tick();

        // 59 frames keep serving, the 60th launches the ball.
        servir_count = 0;
        debut_trame = 1'b1;
        for (int i = 0; i < 59; i++) begin
            tick();
            if (servir) servir_count++;
        end
        checkOutput("serve_early_pulses", servir_count, 0);
        checkOutput("serve_59_etat", int'(etat), 1);
        tick();
        checkOutput("serve_60_servir", int'(servir), 1);
        checkOutput("serve_60_etat", int'(etat), 2);
        debut_trame = 1'b0;
        tick();
        checkOutput("serve_after_servir", int'(servir), 0);

        debut_trame = 1'b1;
        tick();
        checkOutput("frame_maj_high", int'(maj_balle), 1);
        debut_trame = 1'b0;
        tick();
        checkOutput("frame_maj_low", int'(maj_balle), 0);
        checkOutput("frame_x_still", int'(raquette_x), 288);

        //                en plus moins dt col    bp cyc  etat x    briq    score vies maj
        vecs.push_back(mk(1, 1, 0, 0, 3'b000, 0,   3, 2, 288, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 1, 0, 1, 3'b000, 0,  71, 2, 572, 3'b111, 0, 3, 1));
        vecs.push_back(mk(1, 1, 0, 1, 3'b000, 0,   1, 2, 576, 3'b111, 0, 3, 1));
        vecs.push_back(mk(1, 1, 0, 1, 3'b000, 0,   8, 2, 576, 3'b111, 0, 3, 1));
        vecs.push_back(mk(1, 0, 1, 0, 3'b000, 0,   3, 2, 576, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 0, 1, 1, 3'b000, 0,  10, 2, 536, 3'b111, 0, 3, 1));
        vecs.push_back(mk(1, 1, 1, 0, 3'b000, 0,   3, 2, 536, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 1, 1, 1, 3'b000, 0,   5, 2, 536, 3'b111, 0, 3, 1));
        vecs.push_back(mk(1, 0, 1, 0, 3'b000, 0,   3, 2, 536, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 0, 1, 1, 3'b000, 0, 133, 2,   4, 3'b111, 0, 3, 1));
        vecs.push_back(mk(1, 0, 1, 1, 3'b000, 0,   1, 2,   0, 3'b111, 0, 3, 1));
        vecs.push_back(mk(1, 0, 1, 1, 3'b000, 0,  16, 2,   0, 3'b111, 0, 3, 1));
        vecs.push_back(mk(1, 0, 0, 0, 3'b000, 0,   3, 2,   0, 3'b111, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3'b001, 1,   5, 2,   0, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'b000, 0,   1, 2,   0, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'b101, 0,   5, 2,   0, 3'b010, 2, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'b000, 1,   1, 1,   0, 3'b010, 2, 2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'b010, 1,   2, 1,   0, 3'b010, 2, 2, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'b000, 0,  60, 2,   0, 3'b010, 2, 2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'b000, 1,   1, 1,   0, 3'b010, 2, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'b000, 0,  60, 2,   0, 3'b010, 2, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'b000, 1,   1, 4,   0, 3'b010, 2, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'b010, 0,   5, 4,   0, 3'b010, 2, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 3'b000, 0,   3, 4,   0, 3'b010, 2, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 3'b000, 0,   2, 4,   0, 3'b010, 2, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 3'b000, 0,   1, 0, 288, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'b000, 0,   3, 0, 288, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3'b000, 0,   2, 0, 288, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3'b000, 0,   1, 1, 288, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'b000, 0,   3, 1, 288, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'b000, 0,  60, 2, 288, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'b101, 0,   5, 2, 288, 3'b010, 2, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'b111, 0,   1, 3, 288, 3'b000, 3, 3, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'b111, 1,   3, 3, 288, 3'b000, 3, 3, 0));
        vecs.push_back(mk(1, 0, 1, 0, 3'b000, 0,   3, 3, 288, 3'b000, 3, 3, 0));
        vecs.push_back(mk(1, 1, 1, 0, 3'b000, 0,   3, 0, 288, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'b000, 0,   3, 0, 288, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3'b000, 0,   3, 1, 288, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'b000, 0,   3, 1, 288, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'b000, 0,  60, 2, 288, 3'b111, 0, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'b011, 0,   1, 2, 288, 3'b100, 2, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'b011, 0,   2, 2, 288, 3'b100, 2, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'b100, 1,   1, 3, 288, 3'b000, 3, 3, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkAll($sformatf("row%0d", i), int'(vecs[i].e_etat), int'(vecs[i].e_x),
                     int'(vecs[i].e_briq), int'(vecs[i].e_score), int'(vecs[i].e_vies));
            checkOutput($sformatf("row%0d_maj", i), int'(maj_balle), int'(vecs[i].e_maj));
        end

        // Reset takes effect even while frozen.
        enable = 1'b0;
        debut_trame = 1'b0;
        collision_brique = 3'b000;
        balle_perdue = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkAll("frozen_reset", 0, 288, 7, 0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
